fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, drives the synchronous instruction memory, and registers
//  {instr, pc, valid} into the IF/ID boundary for decode. Takes branch/jump redirects from the
//  WB-stage branch logic (branchControl/jumpAddress) and a stall from decode.
//  A skid buffer absorbs in-flight memory responses during stalls, so no fetch is lost or duplicated.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_skid_fifo.sv | 73 +++++++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset/NOP constants, decode field ranges
// and the {pc, instr} record carried through the fetch skid buffer.
package cpu_pkg;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Instruction field bit ranges used by decode
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// DEPTH-entry {pc, instr} FIFO that catches memory responses arriving while decode stalls.
// Flush discards all entries; pointers wrap explicitly so DEPTH need not be a power of two.
module fetch_skid_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // The fetch issue rule keeps skid+inflight within DEPTH, so a push into a full buffer is a bug.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !flush && count_q == CNT_W'(DEPTH)));
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, synchronous imem requests, redirect handling
// and the registered IF/ID boundary, with a skid buffer absorbing responses during stalls.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC   = cpu_pkg::RESET_PC,
    parameter int unsigned        SKID_DEPTH = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid_out
);
    localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);

    logic [ADDR_W-1:0]  pc_fetch_q, pc_fetch_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;

    logic               issue;
    logic               arriving;
    logic               skid_push;
    logic               skid_pop;
    logic               skid_empty;
    logic [CNT_W-1:0]   skid_count;
    fetch_entry_t       skid_head;
    fetch_entry_t       arrive_entry;

    assign issue     = redirect_valid | ~stall |
                       ((32'(skid_count) + 32'(inflight_q)) < SKID_DEPTH);
    assign imem_en   = issue & ~reset;
    assign imem_addr = redirect_valid ? redirect_addr : pc_fetch_q;

    // The old-path word is dropped in the redirect cycle itself; the target issued at the
    // redirect edge is then the only thing in flight, so no separate squash flop is needed.
    assign arriving     = inflight_q & ~redirect_valid;
    assign arrive_entry = '{pc: inflight_pc_q, instr: imem_rdata};
    assign skid_empty   = (skid_count == '0);
    assign skid_push    = arriving & (stall | ~skid_empty);
    assign skid_pop     = ~redirect_valid & ~stall & ~skid_empty;

    fetch_skid_fifo #(
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (skid_push),
        .pop       (skid_pop),
        .flush     (redirect_valid),
        .push_data (arrive_entry),
        .head      (skid_head),
        .count     (skid_count)
    );

    always_comb begin
        pc_fetch_d    = issue ? imem_addr + ADDR_W'(1) : pc_fetch_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? imem_addr : inflight_pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (!skid_empty) begin
                valid_d  = 1'b1;
                instr_d  = skid_head.instr;
                pc_out_d = skid_head.pc;
            end else if (arriving) begin
                valid_d  = 1'b1;
                instr_d  = imem_rdata;
                pc_out_d = inflight_pc_q;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_fetch_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            valid_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_out_q      <= '0;
        end else begin
            pc_fetch_q    <= pc_fetch_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized stall/redirect run checked
// against a stream model (next expected PC, hold-on-stall, bubble-on-redirect).
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .SKID_DEPTH (2),
        .NOP_INSTR  (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // Synchronous instruction memory: data valid the cycle after the request edge
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_checks++;
        if ({valid_out, pc_out, instr_out} !== {1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b pc=%h instr=%h, want v=0 pc=0 instr=0", valid_out, pc_out, instr_out);
        end
        n_checks++;
        if (imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_imem_en: got %0b want 0", imem_en);
        end
    endtask

    task automatic test_first_fetch();
        reset = 1'b0;
        step();
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge_invalid: got v=%0b want 0", valid_out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, 32'(i), mem_word(32'(i))}) begin
                n_fail++;
                $display("FAIL first_fetch[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h", i, valid_out, pc_out, instr_out, 32'(i), mem_word(32'(i)));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 4; i < 6; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out} !== {1'b1, 32'(i)}) begin
                n_fail++;
                $display("FAIL pre_stall[%0d]: got v=%0b pc=%h, want v=1 pc=%h", i, valid_out, pc_out, 32'(i));
            end
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h5, mem_word(32'h5)}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=5", i, valid_out, pc_out, instr_out);
            end
        end
        stall = 1'b0;
        for (int i = 6; i < 9; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, 32'(i), mem_word(32'(i))}) begin
                n_fail++;
                $display("FAIL post_stall[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h", i, valid_out, pc_out, instr_out, 32'(i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if ({valid_out, pc_out} !== {1'b1, 32'h3}) begin
            n_fail++;
            $display("FAIL redirect_setup: got v=%0b pc=%h, want v=1 pc=3", valid_out, pc_out);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        #1;
        n_checks++;
        if ({imem_en, imem_addr} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL redirect_issue: got en=%0b addr=%h, want en=1 addr=40", imem_en, imem_addr);
        end
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if ({valid_out, instr_out} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL redirect_bubble: got v=%0b instr=%h, want v=0 instr=0", valid_out, instr_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h40 + 32'(i), mem_word(32'h40 + 32'(i))}) begin
                n_fail++;
                $display("FAIL redirect_target[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h", i, valid_out, pc_out, instr_out, 32'h40 + 32'(i));
            end
        end
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80;
        stall          = 1'b1;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({valid_out, instr_out} !== {1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL redirect_stall_bubble[%0d]: got v=%0b instr=%h, want v=0 instr=0", i, valid_out, instr_out);
            end
            if (i < 2) step();
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h80 + 32'(i), mem_word(32'h80 + 32'(i))}) begin
                n_fail++;
                $display("FAIL redirect_stall_target[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h", i, valid_out, pc_out, instr_out, 32'h80 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFFF;
        exp_pcs[1] = 32'h0000_0000;
        exp_pcs[2] = 32'h0000_0001;
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_bubble: got v=%0b want 0", valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, exp_pcs[i], mem_word(exp_pcs[i])}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h", i, valid_out, pc_out, instr_out, exp_pcs[i]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if ({valid_out, pc_out} !== {1'b1, 32'h1}) begin
            n_fail++;
            $display("FAIL mid_stall_hold: got v=%0b pc=%h, want v=1 pc=1", valid_out, pc_out);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({valid_out, pc_out, instr_out, imem_en} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b pc=%h instr=%h en=%0b, want all 0", valid_out, pc_out, instr_out, imem_en);
        end
        step();
        stall = 1'b0;
        reset = 1'b0;
        step();
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_bubble: got v=%0b want 0", valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({valid_out, pc_out, instr_out} !== {1'b1, 32'(i), mem_word(32'(i))}) begin
                n_fail++;
                $display("FAIL restart[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h", i, valid_out, pc_out, instr_out, 32'(i));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic        prev_valid;
        logic        rd;
        logic        st;
        exp_pc = '0;
        for (int i = 0; i < 500; i++) begin
            rd  = (i == 0) || ($urandom_range(0, 11) == 0);
            st  = ($urandom_range(0, 2) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            redirect_valid = rd;
            redirect_addr  = tgt;
            stall          = st;
            #1;
            if (rd || !st) begin
                n_checks++;
                if (imem_en !== 1'b1 || (rd && imem_addr !== tgt)) begin
                    n_fail++;
                    $display("FAIL rand_issue[%0d]: got en=%0b addr=%h, want en=1 (addr=%h if redirect=%0b)", i, imem_en, imem_addr, tgt, rd);
                end
            end
            prev_valid = valid_out;
            prev_pc    = pc_out;
            prev_instr = instr_out;
            step();
            n_checks++;
            if (rd) begin
                exp_pc = tgt;
                if ({valid_out, instr_out} !== {1'b0, 32'h0}) begin
                    n_fail++;
                    $display("FAIL rand_redirect[%0d]: got v=%0b instr=%h, want v=0 instr=0", i, valid_out, instr_out);
                end
            end else if (st) begin
                if ({valid_out, pc_out, instr_out} !== {prev_valid, prev_pc, prev_instr}) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: got v=%0b pc=%h instr=%h, want v=%0b pc=%h instr=%h", i, valid_out, pc_out, instr_out, prev_valid, prev_pc, prev_instr);
                end
            end else begin
                if ({valid_out, pc_out, instr_out} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
                    n_fail++;
                    $display("FAIL rand_stream[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h", i, valid_out, pc_out, instr_out, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd1;
            end
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
